branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor for the RISC-V core's fetch stage. It is the front-end counterpart of the branch-resolution logic. At fetch it predicts, from the fetch PC, whether a branch or jump is taken and where it goes. When the branch resolves in execute, the resolved outcome (taken/not-taken plus actual target) is written back to train the tables. The block holds a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry. It also flags mispredictions and counts resolved branches and mispredictions for performance monitoring.

## Interface
- ENTRIES, 64: number of BTB entries; power of two, 4..1024; IDX = log2(ENTRIES).
- XLEN, 32: address width.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_f  in  XLEN  fetch PC to predict.
- pred_hit  out  1  valid entry with matching tag found for pc_f.
- pred_taken  out  1  predicted taken; pred_hit & counter[1].
- pred_target  out  XLEN  stored target on hit; pc_f+4 otherwise.
- upd_valid  in  1  a control-flow instruction resolves this cycle.
- upd_pc  in  XLEN  PC of the resolving instruction.
- upd_is_jump  in  1  unconditional JAL/JALR (branch-type code 6).
- upd_taken  in  1  resolved outcome; always 1 for jumps.
- upd_target  in  XLEN  resolved target address.
- upd_pred_taken  in  1  prediction made for this instruction at fetch, carried down the pipe.
- upd_pred_target  in  XLEN  predicted target carried down the pipe.
- mispredict  out  1  combinational redirect request.
- br_count  out  32  resolved control-flow instructions since reset.
- miss_count  out  32  mispredictions since reset.

## Operation
- Index = PC[IDX+1:2]. Tag = PC[XLEN-1:IDX+2]. PC[1:0] are ignored.
- Each entry holds: valid, tag, target, 2-bit counter (00 strong NT, 01 weak NT, 10 weak T, 11 strong T).
- Prediction is purely combinational from pc_f. A hit requires valid and a tag match.
- Update is applied at the rising edge when upd_valid=1:
  - Hit, conditional branch: counter increments on taken and decrements on not-taken, saturating at 11/00. If taken, target is overwritten with upd_target.
  - Hit, jump: counter is set to 11 and target is overwritten.
  - Miss, taken (branch or jump): entry is allocated or replaced. Valid=1, tag and target are written, counter = 11 for a jump and 10 for a branch.
  - Miss, not taken: no write. The entry (possibly belonging to another PC) is untouched.
- mispredict = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & upd_pred_target != upd_target)).
- br_count increments on every upd_valid. miss_count increments when mispredict=1. Both wrap modulo 2^32.
- Widths: target is stored at full XLEN. pc_f+4 is computed at XLEN and wraps.

## Timing
- Prediction has zero-cycle latency (pc_f to pred_* is combinational). Updates are visible to prediction in the cycle after the update edge.
- Same-cycle read and update of the same index: prediction uses the pre-update contents. There is no bypass.
- mispredict is combinational from the upd_* inputs with no register stage. Counters update on the same edge as the table.
- Reset (any cycle, including while upd_valid=1): all valid bits are cleared, counters are set to 01, br_count=miss_count=0. The reset cycle's update is discarded. Tag and target contents need not be cleared.
- After reset, pred_hit=0, pred_taken=0 and pred_target=pc_f+4 for every pc_f.
- With upd_valid=0, mispredict=0 and no state changes.

## Test plan
- Reset, then pc_f=0x100 → pred_hit=0, pred_taken=0, pred_target=0x104. Counters read 0.
- Update: pc 0x100 taken to 0x80, upd_pred_taken=0. Then pc_f=0x100 → mispredict=1 during the update; next cycle pred_hit=1, pred_taken=1, pred_target=0x80; br_count=1, miss_count=1.
- Training on 0x100: one not-taken update drives the counter 10→01 (pred_taken=0, pred_hit=1). A further not-taken drives it to 00, and two takens bring it back to 10 (pred_taken=1). Saturation is checked at 00 and 11.
- Aliasing with ENTRIES=64: train 0x100 taken. Query 0x200 (same index, different tag) → pred_hit=0. A taken update at 0x200 to 0x300 replaces the entry, and 0x100 then misses.
- Same-cycle update and query at 0x100, first allocation → pred_hit=0 that cycle and 1 the next. A jump update on an existing 00 entry forces the counter to 11.
- Assert rst while upd_valid=1 with a taken update → the entry is not written, and all outputs return to reset values the following cycle.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Fetch/execute-side bundle of the branch predictor: prediction lookup,
// resolution feedback and performance counters.
interface branch_predictor_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] pc_f;
    logic            pred_hit;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;

    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_is_jump;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;
    logic            upd_pred_taken;
    logic [XLEN-1:0] upd_pred_target;

    logic            mispredict;
    logic [31:0]     br_count;
    logic [31:0]     miss_count;

    modport master (
        output pc_f, upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target,
        input  pred_hit, pred_taken, pred_target, mispredict, br_count, miss_count
    );

    modport slave (
        input  pc_f, upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target,
        output pred_hit, pred_taken, pred_target, mispredict, br_count, miss_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: combinational prediction
// at fetch, training from resolved branches, misprediction flag and counters.
module branch_predictor #(
    parameter int ENTRIES = 64,
    parameter int XLEN    = 32
) (
    input logic               clk,
    input logic               rst,
    branch_predictor_if.slave bp
);
    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = XLEN - IDX - 2;

    logic            valid_q  [ENTRIES];
    logic [TAGW-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0] target_q [ENTRIES];
    logic [1:0]      ctr_q    [ENTRIES];
    logic [31:0]     br_q;
    logic [31:0]     miss_q;

    logic [IDX-1:0]  f_idx;
    logic [IDX-1:0]  u_idx;
    logic [TAGW-1:0] f_tag;
    logic [TAGW-1:0] u_tag;
    logic            f_hit;
    logic            u_hit;

    logic            alloc;
    logic            ctr_we;
    logic            tgt_we;
    logic [1:0]      ctr_d;
    logic            unused_pc_bits;

    assign f_idx = bp.pc_f[IDX+1:2];
    assign f_tag = bp.pc_f[XLEN-1:IDX+2];
    assign u_idx = bp.upd_pc[IDX+1:2];
    assign u_tag = bp.upd_pc[XLEN-1:IDX+2];
    assign unused_pc_bits = ^{bp.pc_f[1:0], bp.upd_pc[1:0]};

    // Prediction reads the pre-update table contents; there is no bypass.
    assign f_hit          = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign u_hit          = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign bp.pred_hit    = f_hit;
    assign bp.pred_taken  = f_hit & ctr_q[f_idx][1];
    assign bp.pred_target = f_hit ? target_q[f_idx] : bp.pc_f + XLEN'(4);

    assign bp.mispredict = bp.upd_valid &
                           ((bp.upd_taken != bp.upd_pred_taken) |
                            (bp.upd_taken & (bp.upd_pred_target != bp.upd_target)));
    assign bp.br_count   = br_q;
    assign bp.miss_count = miss_q;

    always_comb begin
        alloc  = 1'b0;
        ctr_we = 1'b0;
        tgt_we = 1'b0;
        ctr_d  = ctr_q[u_idx];
        if (bp.upd_valid) begin
            if (u_hit) begin
                ctr_we = 1'b1;
                if (bp.upd_is_jump) begin
                    ctr_d  = 2'b11;
                    tgt_we = 1'b1;
                end else if (bp.upd_taken) begin
                    tgt_we = 1'b1;
                    if (ctr_q[u_idx] != 2'b11) ctr_d = ctr_q[u_idx] + 2'd1;
                end else if (ctr_q[u_idx] != 2'b00) begin
                    ctr_d = ctr_q[u_idx] - 2'd1;
                end
            end else if (bp.upd_taken) begin
                // A not-taken miss leaves a possibly aliased entry alone.
                alloc  = 1'b1;
                ctr_we = 1'b1;
                tgt_we = 1'b1;
                ctr_d  = bp.upd_is_jump ? 2'b11 : 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
            br_q   <= '0;
            miss_q <= '0;
        end else begin
            if (alloc)          valid_q[u_idx] <= 1'b1;
            if (ctr_we)         ctr_q[u_idx]   <= ctr_d;
            if (bp.upd_valid)   br_q           <= br_q + 32'd1;
            if (bp.mispredict)  miss_q         <= miss_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (alloc)  tag_q[u_idx]    <= u_tag;
            if (tgt_we) target_q[u_idx] <= bp.upd_target;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a behavioural BTB model predicts each
// cycle's outputs, plus fixed expectations for the key training scenarios.
module tb_branch_predictor;
    logic clk;
    logic rst;

    branch_predictor_if #(.XLEN(32)) bp_bus ();

    branch_predictor #(.ENTRIES(64), .XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        hit;
        logic        taken;
        logic [31:0] target;
        logic        mis;
        logic [31:0] br;
        logic [31:0] miss;
    } exp_t;

    exp_t sb[$];

    logic        m_valid  [64];
    logic [23:0] m_tag    [64];
    logic [31:0] m_target [64];
    logic [1:0]  m_ctr    [64];
    logic [31:0] m_br;
    logic [31:0] m_miss;

    int total = 0;
    int bad   = 0;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 2'b01;
        end
        m_br   = 0;
        m_miss = 0;
    endtask

    task automatic modelUpdate(input logic [31:0] upc, input logic jmp, input logic tk,
                               input logic [31:0] tgt, input logic mis);
        int  i;
        logic hit;
        i   = int'(upc[7:2]);
        hit = m_valid[i] && (m_tag[i] == upc[31:8]);
        m_br++;
        if (mis) m_miss++;
        if (hit) begin
            if (jmp) begin
                m_ctr[i]    = 2'b11;
                m_target[i] = tgt;
            end else if (tk) begin
                m_ctr[i]    = (m_ctr[i] == 2'b11) ? 2'b11 : m_ctr[i] + 2'd1;
                m_target[i] = tgt;
            end else begin
                m_ctr[i] = (m_ctr[i] == 2'b00) ? 2'b00 : m_ctr[i] - 2'd1;
            end
        end else if (tk) begin
            m_valid[i]  = 1'b1;
            m_tag[i]    = upc[31:8];
            m_target[i] = tgt;
            m_ctr[i]    = jmp ? 2'b11 : 2'b10;
        end
    endtask

    // One clock cycle: drive, predict, compare mid-cycle, then train the model.
    task automatic applyStimulus(input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                                 input logic jmp, input logic tk, input logic [31:0] tgt,
                                 input logic pt, input logic [31:0] ptgt, input logic r);
        exp_t e;
        exp_t g;
        int   fi;
        bp_bus.pc_f            = pc;
        bp_bus.upd_valid       = uv;
        bp_bus.upd_pc          = upc;
        bp_bus.upd_is_jump     = jmp;
        bp_bus.upd_taken       = tk;
        bp_bus.upd_target      = tgt;
        bp_bus.upd_pred_taken  = pt;
        bp_bus.upd_pred_target = ptgt;
        rst                    = r;
        fi       = int'(pc[7:2]);
        e.hit    = m_valid[fi] && (m_tag[fi] == pc[31:8]);
        e.taken  = e.hit & m_ctr[fi][1];
        e.target = e.hit ? m_target[fi] : pc + 32'd4;
        e.mis    = uv && ((tk != pt) || (tk && (ptgt != tgt)));
        e.br     = m_br;
        e.miss   = m_miss;
        sb.push_back(e);
        #3;
        g = sb.pop_front();
        checkOutput("sb_hit",    {31'b0, bp_bus.pred_hit},   {31'b0, g.hit});
        checkOutput("sb_taken",  {31'b0, bp_bus.pred_taken}, {31'b0, g.taken});
        checkOutput("sb_target", bp_bus.pred_target,         g.target);
        checkOutput("sb_mis",    {31'b0, bp_bus.mispredict}, {31'b0, g.mis});
        checkOutput("sb_br",     bp_bus.br_count,            g.br);
        checkOutput("sb_miss",   bp_bus.miss_count,          g.miss);
        @(posedge clk);
        if (r) modelReset();
        else if (uv) modelUpdate(upc, jmp, tk, tgt, e.mis);
        #1;
        bp_bus.upd_valid = 1'b0;
        rst              = 1'b0;
    endtask

    task automatic query(input logic [31:0] pc);
        applyStimulus(pc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic resolve(input logic [31:0] pc, input logic [31:0] upc, input logic jmp,
                           input logic tk, input logic [31:0] tgt, input logic pt,
                           input logic [31:0] ptgt);
        applyStimulus(pc, 1'b1, upc, jmp, tk, tgt, pt, ptgt, 1'b0);
    endtask

    initial begin
        rst                    = 1'b1;
        bp_bus.pc_f            = 32'h0;
        bp_bus.upd_valid       = 1'b0;
        bp_bus.upd_pc          = 32'h0;
        bp_bus.upd_is_jump     = 1'b0;
        bp_bus.upd_taken       = 1'b0;
        bp_bus.upd_target      = 32'h0;
        bp_bus.upd_pred_taken  = 1'b0;
        bp_bus.upd_pred_target = 32'h0;
        repeat (2) @(posedge clk);
        modelReset();
        #1;
        rst = 1'b0;

        query(32'h100);
        checkOutput("rst_hit",    {31'b0, bp_bus.pred_hit},   32'd0);
        checkOutput("rst_taken",  {31'b0, bp_bus.pred_taken}, 32'd0);
        checkOutput("rst_target", bp_bus.pred_target,         32'h104);
        checkOutput("rst_br",     bp_bus.br_count,            32'd0);

        resolve(32'h100, 32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
        checkOutput("alloc_hit",    {31'b0, bp_bus.pred_hit},   32'd1);
        checkOutput("alloc_taken",  {31'b0, bp_bus.pred_taken}, 32'd1);
        checkOutput("alloc_target", bp_bus.pred_target,         32'h80);
        checkOutput("alloc_br",     bp_bus.br_count,            32'd1);
        checkOutput("alloc_miss",   bp_bus.miss_count,          32'd1);

        resolve(32'h100, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80);
        checkOutput("wnt_hit",   {31'b0, bp_bus.pred_hit},   32'd1);
        checkOutput("wnt_taken", {31'b0, bp_bus.pred_taken}, 32'd0);
        resolve(32'h100, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h104);
        resolve(32'h100, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h104);
        checkOutput("sat_lo", {31'b0, bp_bus.pred_taken}, 32'd0);
        resolve(32'h100, 32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
        resolve(32'h100, 32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
        checkOutput("retrain_taken", {31'b0, bp_bus.pred_taken}, 32'd1);
        resolve(32'h100, 32'h100, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80);
        resolve(32'h100, 32'h100, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80);
        resolve(32'h100, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80);
        checkOutput("sat_hi", {31'b0, bp_bus.pred_taken}, 32'd1);

        query(32'h200);
        checkOutput("alias_hit", {31'b0, bp_bus.pred_hit}, 32'd0);
        resolve(32'h100, 32'h200, 1'b0, 1'b0, 32'h0, 1'b0, 32'h204);
        checkOutput("nt_miss_nowrite", {31'b0, bp_bus.pred_hit}, 32'd1);
        resolve(32'h200, 32'h200, 1'b0, 1'b1, 32'h300, 1'b0, 32'h204);
        checkOutput("replace_hit",    {31'b0, bp_bus.pred_hit}, 32'd1);
        checkOutput("replace_target", bp_bus.pred_target,       32'h300);
        query(32'h100);
        checkOutput("evicted_hit", {31'b0, bp_bus.pred_hit}, 32'd0);

        resolve(32'h404, 32'h404, 1'b0, 1'b1, 32'h500, 1'b0, 32'h408);
        checkOutput("same_cyc_next", {31'b0, bp_bus.pred_hit}, 32'd1);
        resolve(32'h404, 32'h404, 1'b0, 1'b0, 32'h0, 1'b1, 32'h500);
        resolve(32'h404, 32'h404, 1'b0, 1'b0, 32'h0, 1'b0, 32'h408);
        checkOutput("pre_jump_taken", {31'b0, bp_bus.pred_taken}, 32'd0);
        resolve(32'h404, 32'h404, 1'b1, 1'b1, 32'h600, 1'b0, 32'h408);
        checkOutput("jump_target", bp_bus.pred_target, 32'h600);
        resolve(32'h404, 32'h404, 1'b0, 1'b0, 32'h0, 1'b1, 32'h600);
        checkOutput("jump_ctr11", {31'b0, bp_bus.pred_taken}, 32'd1);
        resolve(32'h404, 32'h404, 1'b0, 1'b1, 32'h600, 1'b1, 32'h700);

        applyStimulus(32'h404, 1'b0, 32'h404, 1'b0, 1'b1, 32'h999, 1'b0, 32'h123, 1'b0);
        checkOutput("idle_br",   bp_bus.br_count,   m_br);
        checkOutput("idle_miss", bp_bus.miss_count, m_miss);

        query(32'hFFFF_FFFC);
        checkOutput("wrap_target", bp_bus.pred_target, 32'h0);

        applyStimulus(32'h808, 1'b1, 32'h808, 1'b0, 1'b1, 32'h900, 1'b0, 32'h80C, 1'b1);
        checkOutput("rstupd_hit",    {31'b0, bp_bus.pred_hit}, 32'd0);
        checkOutput("rstupd_target", bp_bus.pred_target,       32'h80C);
        checkOutput("rstupd_br",     bp_bus.br_count,          32'd0);
        checkOutput("rstupd_miss",   bp_bus.miss_count,        32'd0);
        query(32'h404);
        checkOutput("rst_clear_hit", {31'b0, bp_bus.pred_hit}, 32'd0);

        checkOutput("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
